// File: rtl/mul4_bist_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mul4_bist_sequencer
// Brief    : Sweeps all 256 operand pairs of a 4-bit multiplier, checks each
//            product against x*y and reports pass/fail with first-fail capture.
// Revision : 1.0 - initial release
// ============================================================================
module mul4_bist_sequencer #(
    parameter int SETTLE = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] prod_in,
    output logic [3:0] x_out,
    output logic [3:0] y_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [8:0] err_count,
    output logic       fail_valid,
    output logic [3:0] fail_x,
    output logic [3:0] fail_y,
    output logic [7:0] fail_prod
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_RUN    = 2'd1;
    localparam logic [1:0] c_DONE   = 2'd2;
    localparam logic [3:0] c_SETTLE = 4'(SETTLE);

    logic [1:0] r_state;
    logic [7:0] r_idx;
    logic [3:0] r_wait;
    logic [8:0] r_err;
    logic       r_fail_valid;
    logic [3:0] r_fail_x;
    logic [3:0] r_fail_y;
    logic [7:0] r_fail_prod;
    logic       r_busy;
    logic       r_done;

    logic [7:0] w_expected;
    logic       w_mismatch;

    assign w_expected = {4'b0, r_idx[7:4]} * {4'b0, r_idx[3:0]};
    assign w_mismatch = (prod_in != w_expected);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_IDLE;
            r_idx        <= 8'd0;
            r_wait       <= 4'd0;
            r_err        <= 9'd0;
            r_fail_valid <= 1'b0;
            r_fail_x     <= 4'd0;
            r_fail_y     <= 4'd0;
            r_fail_prod  <= 8'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else if (abort) begin
            // Error statistics are deliberately kept so a halted sweep can be inspected.
            r_state <= c_IDLE;
            r_idx   <= 8'd0;
            r_wait  <= 4'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE, c_DONE: begin
                    if (start) begin
                        r_state      <= c_RUN;
                        r_idx        <= 8'd0;
                        r_wait       <= c_SETTLE;
                        r_err        <= 9'd0;
                        r_fail_valid <= 1'b0;
                        r_fail_x     <= 4'd0;
                        r_fail_y     <= 4'd0;
                        r_fail_prod  <= 8'd0;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                    end
                end
                c_RUN: begin
                    if (r_wait != 4'd0) begin
                        r_wait <= r_wait - 4'd1;
                    end else begin
                        if (w_mismatch) begin
                            r_err <= r_err + 9'd1;
                            if (!r_fail_valid) begin
                                r_fail_valid <= 1'b1;
                                r_fail_x     <= r_idx[7:4];
                                r_fail_y     <= r_idx[3:0];
                                r_fail_prod  <= prod_in;
                            end
                        end
                        // The last vector leaves idx at 255 so the operands hold 15/15 in DONE.
                        if (r_idx == 8'hFF) begin
                            r_state <= c_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_idx  <= r_idx + 8'd1;
                            r_wait <= c_SETTLE;
                        end
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign x_out      = r_idx[7:4];
    assign y_out      = r_idx[3:0];
    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_done && (r_err == 9'd0);
    assign err_count  = r_err;
    assign fail_valid = r_fail_valid;
    assign fail_x     = r_fail_x;
    assign fail_y     = r_fail_y;
    assign fail_prod  = r_fail_prod;

endmodule
`default_nettype wire

// File: tb/tb_mul4_bist_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul4_bist_sequencer
// Brief    : Bench for mul4_bist_sequencer with SETTLE=0 and SETTLE=2 instances,
//            a fault-injectable multiplier stand-in and a time-based reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul4_bist_sequencer;

    typedef struct packed {
        logic [8:0] err;
        logic       fv;
        logic [3:0] fx;
        logic [3:0] fy;
        logic [7:0] fp;
    } stat_t;

    logic       clk = 1'b0;
    logic       rn[2];
    logic       st[2];
    logic       ab[2];
    logic [7:0] prod[2];
    logic [3:0] ox[2];
    logic [3:0] oy[2];
    logic       ob[2];
    logic       odn[2];
    logic       op[2];
    logic [8:0] oe[2];
    logic       ofv[2];
    logic [3:0] ofx[2];
    logic [3:0] ofy[2];
    logic [7:0] ofp[2];

    logic [7:0] cur_am[2];
    logic [7:0] cur_om[2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    // reference state: mode 0 idle, 1 sweeping, 2 finished
    int    m_mode[2];
    int    m_t0[2];
    stat_t m_hold[2];
    logic [7:0] m_am[2];
    logic [7:0] m_om[2];
    int    per[2];

    always #5 clk = ~clk;

    mul4_bist_sequencer #(.SETTLE(0)) dut0 (
        .clk(clk), .rst_n(rn[0]), .start(st[0]), .abort(ab[0]), .prod_in(prod[0]),
        .x_out(ox[0]), .y_out(oy[0]), .busy(ob[0]), .done(odn[0]), .pass(op[0]),
        .err_count(oe[0]), .fail_valid(ofv[0]), .fail_x(ofx[0]), .fail_y(ofy[0]),
        .fail_prod(ofp[0])
    );

    mul4_bist_sequencer #(.SETTLE(2)) dut2 (
        .clk(clk), .rst_n(rn[1]), .start(st[1]), .abort(ab[1]), .prod_in(prod[1]),
        .x_out(ox[1]), .y_out(oy[1]), .busy(ob[1]), .done(odn[1]), .pass(op[1]),
        .err_count(oe[1]), .fail_valid(ofv[1]), .fail_x(ofx[1]), .fail_y(ofy[1]),
        .fail_prod(ofp[1])
    );

    function automatic logic [7:0] mul_out(logic [3:0] x, logic [3:0] y,
                                           logic [7:0] am, logic [7:0] om);
        return ((8'(x) * 8'(y)) & am) | om;
    endfunction

    // Multiplier stand-in: ideal product with stuck-at-0 / stuck-at-1 masks.
    always_comb begin
        for (int d = 0; d < 2; d++) prod[d] = mul_out(ox[d], oy[d], cur_am[d], cur_om[d]);
    end

    // Statistics after the first k vectors of a sweep have been compared.
    function automatic stat_t stats(int d, int k);
        stat_t s;
        logic [3:0] x, y;
        logic [7:0] p;
        s = '0;
        for (int v = 0; v < k; v++) begin
            x = 4'(v / 16);
            y = 4'(v % 16);
            p = mul_out(x, y, m_am[d], m_om[d]);
            if (p != 8'(x) * 8'(y)) begin
                if (!s.fv) begin
                    s.fv = 1'b1; s.fx = x; s.fy = y; s.fp = p;
                end
                s.err = s.err + 9'd1;
            end
        end
        return s;
    endfunction

    always @(posedge clk) begin
        cyc = cyc + 1;
        for (int d = 0; d < 2; d++) begin
            if (!rn[d]) begin
                m_mode[d] = 0;
                m_hold[d] = '0;
            end else if (ab[d]) begin
                if (m_mode[d] == 1) m_hold[d] = stats(d, (cyc - 1 - m_t0[d]) / per[d]);
                else if (m_mode[d] == 2) m_hold[d] = stats(d, 256);
                m_mode[d] = 0;
            end else if (st[d] && m_mode[d] != 1) begin
                m_mode[d] = 1;
                m_t0[d]   = cyc;
                m_am[d]   = cur_am[d];
                m_om[d]   = cur_om[d];
            end else if (m_mode[d] == 1 && cyc - m_t0[d] == 256 * per[d]) begin
                m_mode[d] = 2;
            end
        end
    end

    // Per-cycle comparison of every output against the reference.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                logic [36:0] exp_v, act_v;
                stat_t s;
                int k;
                exp_v = '0;
                if (rn[d]) begin
                    case (m_mode[d])
                        1: begin
                            k = (cyc - m_t0[d]) / per[d];
                            s = stats(d, k);
                            exp_v = {4'(k / 16), 4'(k % 16), 1'b1, 1'b0, 1'b0, s};
                        end
                        2: begin
                            s = stats(d, 256);
                            exp_v = {4'hF, 4'hF, 1'b0, 1'b1, s.err == 9'd0, s};
                        end
                        default: exp_v = {4'h0, 4'h0, 3'b000, m_hold[d]};
                    endcase
                end
                act_v = {ox[d], oy[d], ob[d], odn[d], op[d], oe[d], ofv[d], ofx[d], ofy[d], ofp[d]};
                total++;
                if (act_v !== exp_v) begin
                    bad++;
                    $display("FAIL cycle_dut%0d @%0d: got %h expected %h", d, cyc, act_v, exp_v);
                end
            end
        end
    end

    task automatic check(string nm, int act, int exp_val);
        total++;
        if (act != exp_val) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_val);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    // Pulse start; returns the edge number that sampled it.
    task automatic pulse_start(int d, logic [7:0] am, logic [7:0] om, output int e0);
        cur_am[d] = am;
        cur_om[d] = om;
        st[d] = 1'b1;
        tick(1);
        st[d] = 1'b0;
        e0 = cyc;
    endtask

    task automatic wait_done(int d, int e0, output int lat);
        int n = 0;
        while (!odn[d] && n < 2000) begin
            tick(1);
            n++;
        end
        if (!odn[d]) check("done_timeout", 0, 1);
        lat = cyc - e0;
    endtask

    initial begin
        int e0, lat, d, kind, b;
        per = '{1, 3};
        m_mode = '{0, 0};
        m_t0 = '{0, 0};
        m_hold = '{'0, '0};
        m_am = '{8'hFF, 8'hFF};
        m_om = '{8'h00, 8'h00};
        cur_am = '{8'hFF, 8'hFF};
        cur_om = '{8'h00, 8'h00};
        st = '{1'b0, 1'b0};
        ab = '{1'b0, 1'b0};
        rn = '{1'b1, 1'b1};
        #1 rn = '{1'b0, 1'b0};
        #1;
        check("reset_err", int'(oe[0]), 0);
        check("reset_busy_done", int'({ob[0], odn[0], op[0]}), 0);
        tick(2);
        rn = '{1'b1, 1'b1};
        chk_en = 1'b1;
        tick(2);

        // Ideal sweep with a stray start 100 cycles into RUN.
        pulse_start(0, 8'hFF, 8'h00, e0);
        check("start_busy", int'(ob[0]), 1);
        check("start_xy", int'({ox[0], oy[0]}), 0);
        tick(100);
        st[0] = 1'b1;
        tick(1);
        st[0] = 1'b0;
        wait_done(0, e0, lat);
        check("ideal_latency", lat, 256);
        check("ideal_pass", int'(op[0]), 1);
        check("ideal_fail_valid", int'(ofv[0]), 0);
        check("done_xy", int'({ox[0], oy[0]}), 8'hFF);
        tick(3);

        // Restart from DONE with prod bit0 stuck at 0.
        pulse_start(0, 8'hFE, 8'h00, e0);
        check("restart_cleared", int'(oe[0]), 0);
        wait_done(0, e0, lat);
        check("bit0_err", int'(oe[0]), 64);
        check("bit0_fail_xy", int'({ofx[0], ofy[0]}), 8'h11);
        check("bit0_fail_prod", int'(ofp[0]), 0);
        check("bit0_pass", int'(op[0]), 0);
        tick(2);

        // Restart from DONE with an ideal multiplier clears the earlier failures.
        pulse_start(0, 8'hFF, 8'h00, e0);
        wait_done(0, e0, lat);
        check("clean_pass", int'(op[0]), 1);
        check("clean_err", int'(oe[0]), 0);
        tick(2);

        // Abort 50 cycles in with bit0 stuck: 49 vectors compared, 8 odd*odd.
        pulse_start(0, 8'hFE, 8'h00, e0);
        tick(49);
        ab[0] = 1'b1;
        tick(1);
        ab[0] = 1'b0;
        check("abort_busy_done", int'({ob[0], odn[0]}), 0);
        check("abort_err", int'(oe[0]), 8);
        check("abort_fail_valid", int'(ofv[0]), 1);
        tick(3);

        // Asynchronous reset 130 cycles into a sweep.
        pulse_start(0, 8'hFE, 8'h00, e0);
        tick(129);
        @(posedge clk);
        #2 rn[0] = 1'b0;
        #1;
        check("async_rst_outs", int'({ox[0], oy[0], ob[0], odn[0], ofv[0], ofx[0], ofy[0], ofp[0]}), 0);
        check("async_rst_err", int'(oe[0]), 0);
        tick(2);
        rn[0] = 1'b1;
        tick(1);
        pulse_start(0, 8'hFF, 8'h00, e0);
        wait_done(0, e0, lat);
        check("post_rst_latency", lat, 256);
        check("post_rst_pass", int'(op[0]), 1);

        // SETTLE=2 instance: three cycles per operand pair.
        pulse_start(1, 8'hFF, 8'h00, e0);
        wait_done(1, e0, lat);
        check("settle2_latency", lat, 768);
        check("settle2_pass", int'(op[1]), 1);
        tick(2);

        // Randomized faults and occasional random aborts on both instances.
        for (int r = 0; r < 6; r++) begin
            logic [7:0] am, om;
            d = r % 2;
            kind = int'($urandom_range(0, 2));
            b = int'($urandom_range(0, 7));
            am = 8'hFF;
            om = 8'h00;
            if (kind == 1) am = ~(8'h01 << b);
            if (kind == 2) om = 8'h01 << b;
            pulse_start(d, am, om, e0);
            if ($urandom_range(0, 1) == 1) begin
                tick(int'($urandom_range(0, 256 * per[d] - 2)));
                ab[d] = 1'b1;
                tick(1);
                ab[d] = 1'b0;
                tick(3);
            end else begin
                wait_done(d, e0, lat);
                check("rand_latency", lat, 256 * per[d]);
                tick(2);
            end
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mul4_bist_sequencer.md
# mul4_bist_sequencer

Self-checking operand sequencer for the 4-bit Vedic multiplier `Multiplier4bit`. It sweeps all 256 (x, y) operand pairs in the same order the existing bench uses: x outer, y inner, both ascending. It drives the pairs onto the multiplier inputs, samples the 8-bit product after a programmable settle time, and compares it against an internally computed x*y. It sits directly upstream and downstream of the multiplier: `x_out`/`y_out` feed `Multiplier4bit.x`/`.y`, and `Multiplier4bit.out` returns on `prod_in`. It provides an on-chip pass/fail result without a simulator.

## Interface
- `SETTLE`, default 0: extra idle cycles per vector between operand update and product sampling. Legal range 0–15.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `start` input, 1 bit: begin a sweep. Sampled only in IDLE or DONE.
- `abort` input, 1 bit: synchronous abort. Highest priority after reset.
- `prod_in` input, 8 bits: product from the multiplier under test.
- `x_out` output, 4 bits: registered operand x to the multiplier.
- `y_out` output, 4 bits: registered operand y to the multiplier.
- `busy` output, 1 bit: high while in RUN.
- `done` output, 1 bit: high in DONE; held until the next start or reset.
- `pass` output, 1 bit: `done` AND `err_count == 0`.
- `err_count` output, 9 bits: number of mismatching vectors, range 0..256.
- `fail_valid` output, 1 bit: a mismatch has been recorded this sweep.
- `fail_x` output, 4 bits: x of the first mismatching vector.
- `fail_y` output, 4 bits: y of the first mismatching vector.
- `fail_prod` output, 8 bits: `prod_in` observed at the first mismatch.

## Operation
- States: IDLE, RUN, DONE.
- Internal signals:
  - `idx[7:0]`: `x_out = idx[7:4]`, `y_out = idx[3:0]`.
  - `wait_cnt[3:0]`.
  - `expected = {4'b0,x_out} * {4'b0,y_out}`: 8-bit, full precision, no truncation (max 225).
- IDLE, `start=1`:
  - `idx` ← 0, `wait_cnt` ← SETTLE.
  - `err_count`, `fail_valid`, `fail_*` ← 0.
  - Next state RUN.
- RUN, `wait_cnt != 0`: `wait_cnt` decrements; no compare.
- RUN, `wait_cnt == 0`: compare `prod_in` with `expected`.
  - On mismatch, `err_count` increments (it cannot exceed 256).
  - If `fail_valid` is 0, capture `fail_x/y/prod` and set `fail_valid`. Later mismatches never overwrite the capture.
  - If `idx == 255`, go to DONE. Otherwise `idx` increments and `wait_cnt` reloads to SETTLE.
- `start` during RUN is ignored.
- DONE, `start=1`: same action as IDLE+start. This is a full restart with results cleared.
- `abort=1` in any state:
  - Next state IDLE; `idx` ← 0.
  - `err_count` and `fail_*` are retained for debug.
  - `abort` and `start` asserted together: `abort` wins.
- Reset (asynchronous, any time including mid-sweep): state IDLE; every output and internal register is 0.

## Timing
- Per-vector period is SETTLE+1 cycles.
- Operands change on the edge that enters the vector. The compare happens on the edge SETTLE+1 cycles later, so the multiplier path gets SETTLE+1 full cycles.
- Start latency: `start` sampled at edge E0. At E0, `busy`=1 and `x_out`/`y_out`=0.
- Sweep length: the final compare occurs at edge E0 + 256·(SETTLE+1). At that same edge, `busy`=0, `done`=1, and `pass` is valid.
- `err_count` and `fail_*` update on the compare edge itself. They are visible the cycle after.
- In DONE, `x_out`/`y_out` hold 15/15.
- Abort at edge A: `busy`=0 and `done`=0 from A onward.

## Test plan
- SETTLE=0, ideal multiplier: pulse `start` → `done` and `pass` both 1 exactly 256 cycles after the start edge; `err_count`=0; `fail_valid`=0; `x_out`/`y_out` walk 0/0, 0/1 … 15/15.
- SETTLE=0, `prod_in` bit0 forced 0: → `err_count`=64 (odd×odd pairs); `fail_x`=1, `fail_y`=1, `fail_prod`=8'h00; `pass`=0.
- SETTLE=2, ideal multiplier: → `done` at 768 cycles; each operand pair held 3 cycles; `pass`=1.
- Robustness: `start` pulsed at cycle 100 of RUN → ignored, `done` still at 256. Second `start` in DONE → results cleared, new sweep completes with `pass`=1.
- Abort: `abort` at cycle 50 with a stuck-bit fault injected → IDLE, `busy`=0, `done`=0, `err_count` retained (value at cycle 50), `fail_valid`=1.
- Reset mid-sweep: `rst_n` low asynchronously at cycle 130 → all outputs 0 immediately. After release, `start` yields a clean full sweep.
